// File: rtl/hazard_sequencer_pkg.sv
// hazard_pkg: shared FSM state encoding and parameter defaults for the hazard sequencer
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT, RESUME} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int WAIT_MAX_DEF = 255;
endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// sat_counter: event counter that saturates at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use stall, branch flush and data-miss freeze control with event counters
module hazard_sequencer import hazard_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS_i,
  input  logic [4:0]       IFID_RT_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RT_i,
  input  logic             Branch_taken_i,
  input  logic             DMem_req_i,
  input  logic             DMem_hit_i,
  input  logic             Mem_ack_i,
  output logic             Mem_req_o,
  output logic             PC_Write_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             Pipe_Freeze_o,
  output logic [CNT_W-1:0] Stall_cnt_o,
  output logic [CNT_W-1:0] Flush_cnt_o,
  output logic             Timeout_o
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic miss, freeze, load_use;
  assign miss = state == RUN && DMem_req_i && !DMem_hit_i;
  assign freeze = state != RUN || miss;
  assign load_use = IDEX_MemRead_i && IDEX_RT_i != '0 && (IDEX_RT_i == IFID_RS_i || IDEX_RT_i == IFID_RT_i);
  assign Pipe_Freeze_o = freeze;
  assign PC_Write_o = !freeze && !load_use;
  assign IFID_Write_o = !freeze && !load_use;
  assign IDEX_Bubble_o = !freeze && load_use;
  assign IFID_Flush_o = !freeze && !load_use && Branch_taken_i;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= RUN;
      wait_cnt <= '0;
      Timeout_o <= 1'b0;
      Mem_req_o <= 1'b0;
    end else
      case (state)
        RUN: if (miss) begin
          state <= MISS_REQ;
          Mem_req_o <= 1'b1;
        end
        MISS_REQ: begin
          state <= Mem_ack_i ? RESUME : MISS_WAIT;
          Mem_req_o <= !Mem_ack_i;
          wait_cnt <= '0;
        end
        MISS_WAIT: begin
          if (wait_cnt != WW'(WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WW'(WAIT_MAX - 1)) Timeout_o <= 1'b1;
          if (Mem_ack_i) begin
            state <= RESUME;
            Mem_req_o <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk_i), .rst(rst_i), .inc(!PC_Write_o), .count(Stall_cnt_o));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk_i), .rst(rst_i), .inc(IFID_Flush_o), .count(Flush_cnt_o));
endmodule
